// File: rtl/lsu_mem_stage_pkg.sv
// rtl/lsu_mem_stage_pkg.sv - shared constants, state encoding and access legality check for the LSU
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Illegal encodings take priority over misalignment; bytes never misalign.
  function automatic logic [1:0] access_check(input logic rd, input logic wr,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] c;
    c = CAUSE_NONE;
    if (rd && wr)                                     c = CAUSE_ILLEGAL;
    else if (wr && f3 > F3_W)                         c = CAUSE_ILLEGAL;
    else if (rd && (f3 == 3'b011 || f3[2:1] == 2'b11)) c = CAUSE_ILLEGAL;
    else if (f3[1:0] == 2'b10 && off != 2'b00)        c = CAUSE_MISALIGN;
    else if (f3[1:0] == 2'b01 && off[0])              c = CAUSE_MISALIGN;
    return c;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// rtl/lsu_mem_stage_load_align.sv - extracts the addressed byte/half/word from a read word and extends it
module lsu_load_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'b0, shifted[7:0]};
      F3_HU:   load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - load/store unit: one req/ack data-memory transaction per load or store
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [1:0]       chk;
  logic             access, start, reject, timeout;
  logic [3:0]       be_nx;
  logic [31:0]      wdata_nx, aligned;

  assign access = mem_read | mem_write;
  assign chk    = access_check(mem_read, mem_write, funct3, addr[1:0]);

  // While a fault pulse is out the stalled instruction is still present; it must not restart.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    reject   = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (access && !fault) begin
          if (chk == CAUSE_NONE) begin
            start    = 1'b1;
            state_nx = BUSY;
          end else begin
            reject = 1'b1;
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_nx = RESP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_nx    = 4'b0001 << addr[1:0];
        wdata_nx = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_nx    = 4'b0011 << {addr[1], 1'b0};
        wdata_nx = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    if (!mem_write) wdata_nx = '0;
  end

  assign dmem_req = (state == BUSY);
  assign stall    = start | (state == BUSY);
  assign done     = (state == RESP);

  lsu_load_align u_align (
    .rdata    (dmem_rdata),
    .byte_off (off_q),
    .funct3   (f3_q),
    .load_data(aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      load_data   <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      state       <= state_nx;
      fault       <= reject | timeout;
      fault_cause <= reject ? chk : (timeout ? CAUSE_TIMEOUT : CAUSE_NONE);
      if (start) begin
        cnt        <= '0;
        dmem_we    <= mem_write;
        dmem_addr  <= {addr[31:2], 2'b00};
        dmem_be    <= be_nx;
        dmem_wdata <= wdata_nx;
        f3_q       <= funct3;
        off_q      <= addr[1:0];
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == BUSY && dmem_ack) load_data <= dmem_we ? '0 : aligned;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        done, fault;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .load_data(load_data), .done(done), .fault(fault), .fault_cause(fault_cause)
  );

  // Result of one access as seen by a core that advances whenever stall is low.
  int          r_stalls, r_done_at, r_fault_at, r_req, r_unstable, r_both;
  logic [31:0] r_ld, r_addr, r_wd;
  logic [3:0]  r_be;
  logic        r_we;
  logic [1:0]  r_cause;

  // Called at posedge+1 with the unit idle; ack_at < 0 means the bus never acks.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int ack_at, input logic [31:0] rdat);
    logic prev_stall;
    r_stalls = 0; r_done_at = -1; r_fault_at = -1; r_req = 0; r_unstable = 0; r_both = 0;
    r_ld = '0; r_addr = '0; r_wd = '0; r_be = '0; r_we = 1'b0; r_cause = 2'b00;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    prev_stall = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (!prev_stall) begin mem_read = 1'b0; mem_write = 1'b0; end
      dmem_ack   = (c == ack_at);
      dmem_rdata = (c == ack_at) ? rdat : 32'h5A5A_5A5A;
      #1;
      prev_stall = stall;
      if (stall) r_stalls++;
      if (dmem_req) begin
        if (r_req == 0) begin
          r_addr = dmem_addr; r_be = dmem_be; r_wd = dmem_wdata; r_we = dmem_we;
        end else if (dmem_addr !== r_addr || dmem_be !== r_be || dmem_wdata !== r_wd || dmem_we !== r_we) begin
          r_unstable++;
        end
        r_req++;
      end
      if (done && r_done_at < 0) begin r_done_at = c; r_ld = load_data; end
      if (fault && r_fault_at < 0) begin r_fault_at = c; r_cause = fault_cause; end
      if (done && fault) r_both++;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", dmem_req); end
    n_checks++; if (done !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got done=%0b fault=%0b want 0 0", done, fault); end
    n_checks++; if (fault_cause !== 2'b00 || load_data !== 32'h0) begin n_fail++; $display("FAIL reset_regs got cause=%b ld=%h want 00 0", fault_cause, load_data); end
    n_checks++; if (dmem_addr !== 32'h0 || dmem_be !== 4'h0 || dmem_wdata !== 32'h0 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus got a=%h be=%b wd=%h we=%0b want zeros", dmem_addr, dmem_be, dmem_wdata, dmem_we); end
  endtask

  task automatic test_store_word;
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0);
    n_checks++; if (r_addr !== 32'h100 || r_be !== 4'b1111 || r_wd !== 32'hDEAD_BEEF || r_we !== 1'b1) begin n_fail++; $display("FAIL sw_bus got a=%h be=%b wd=%h we=%0b want 100 1111 deadbeef 1", r_addr, r_be, r_wd, r_we); end
    n_checks++; if (r_stalls !== 3 || r_done_at !== 3) begin n_fail++; $display("FAIL sw_timing got stalls=%0d done_at=%0d want 3 3", r_stalls, r_done_at); end
    n_checks++; if (r_req !== 2 || r_unstable !== 0 || r_fault_at !== -1) begin n_fail++; $display("FAIL sw_req got req=%0d unstable=%0d fault_at=%0d want 2 0 -1", r_req, r_unstable, r_fault_at); end
  endtask

  task automatic test_store_sub;
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0);
    n_checks++; if (r_addr !== 32'h100 || r_be !== 4'b1000 || r_wd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_bus got a=%h be=%b wd=%h want 100 1000 a5a5a5a5", r_addr, r_be, r_wd); end
    n_checks++; if (r_done_at !== 2 || r_stalls !== 2) begin n_fail++; $display("FAIL sb_timing got done_at=%0d stalls=%0d want 2 2", r_done_at, r_stalls); end
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 1, 32'h0);
    n_checks++; if (r_be !== 4'b1100 || r_wd !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_bus got be=%b wd=%h want 1100 abcdabcd", r_be, r_wd); end
  endtask

  task automatic test_loads;
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h8001_1234);
    n_checks++; if (r_ld !== 32'hFFFF_8001 || r_be !== 4'b1100 || r_we !== 1'b0) begin n_fail++; $display("FAIL lh got ld=%h be=%b we=%0b want ffff8001 1100 0", r_ld, r_be, r_we); end
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 1, 32'h0000_F000);
    n_checks++; if (r_ld !== 32'h0000_00F0) begin n_fail++; $display("FAIL lbu got %h want 000000f0", r_ld); end
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 1, 32'h0000_F000);
    n_checks++; if (r_ld !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL lb got %h want fffffff0", r_ld); end
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 1, 32'h9ABC_0000);
    n_checks++; if (r_ld !== 32'h0000_9ABC) begin n_fail++; $display("FAIL lhu got %h want 00009abc", r_ld); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0, 1, 32'h8765_4321);
    n_checks++; if (r_ld !== 32'h8765_4321 || r_addr !== 32'h204) begin n_fail++; $display("FAIL lw got ld=%h a=%h want 87654321 204", r_ld, r_addr); end
  endtask

  task automatic test_faults;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h0);
    n_checks++; if (r_req !== 0 || r_stalls !== 0 || r_fault_at !== 1 || r_cause !== 2'b01 || r_done_at !== -1) begin n_fail++; $display("FAIL misalign_lw got req=%0d stalls=%0d fault_at=%0d cause=%b done_at=%0d want 0 0 1 01 -1", r_req, r_stalls, r_fault_at, r_cause, r_done_at); end
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0, 0, 32'h0);
    n_checks++; if (r_req !== 0 || r_fault_at !== 1 || r_cause !== 2'b01) begin n_fail++; $display("FAIL misalign_sh got req=%0d fault_at=%0d cause=%b want 0 1 01", r_req, r_fault_at, r_cause); end
    run_access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
    n_checks++; if (r_req !== 0 || r_fault_at !== 1 || r_cause !== 2'b10) begin n_fail++; $display("FAIL illegal_ld got req=%0d fault_at=%0d cause=%b want 0 1 10", r_req, r_fault_at, r_cause); end
    run_access(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h0);
    n_checks++; if (r_req !== 0 || r_fault_at !== 1 || r_cause !== 2'b10) begin n_fail++; $display("FAIL illegal_st got req=%0d fault_at=%0d cause=%b want 0 1 10", r_req, r_fault_at, r_cause); end
    run_access(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 0, 32'h0);
    n_checks++; if (r_req !== 0 || r_fault_at !== 1 || r_cause !== 2'b10) begin n_fail++; $display("FAIL rd_and_wr got req=%0d fault_at=%0d cause=%b want 0 1 10", r_req, r_fault_at, r_cause); end
  endtask

  task automatic test_timeout;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, -1, 32'h0);
    n_checks++; if (r_req !== 4 || r_stalls !== 5) begin n_fail++; $display("FAIL timeout_req got req=%0d stalls=%0d want 4 5", r_req, r_stalls); end
    n_checks++; if (r_fault_at !== 5 || r_cause !== 2'b11 || r_done_at !== -1) begin n_fail++; $display("FAIL timeout_fault got fault_at=%0d cause=%b done_at=%0d want 5 11 -1", r_fault_at, r_cause, r_done_at); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 4, 32'hCAFE_F00D);
    n_checks++; if (r_done_at !== 5 || r_fault_at !== -1 || r_ld !== 32'hCAFE_F00D || r_both !== 0) begin n_fail++; $display("FAIL ack_wins got done_at=%0d fault_at=%0d ld=%h both=%0d want 5 -1 cafef00d 0", r_done_at, r_fault_at, r_ld, r_both); end
  endtask

  task automatic test_reset_mid_busy;
    logic saw_pulse;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre got req=%0b want 1", dmem_req); end
    #2 rst_n = 1'b0; mem_read = 1'b0;
    #1;
    n_checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_async got req=%0b stall=%0b want 0 0", dmem_req, stall); end
    saw_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || fault) saw_pulse = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done || fault) saw_pulse = 1'b1;
    end
    n_checks++; if (saw_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_no_pulse got %0b want 0", saw_pulse); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 1, 32'h1234_5678);
    n_checks++; if (r_done_at !== 2 || r_ld !== 32'h1234_5678 || r_fault_at !== -1) begin n_fail++; $display("FAIL rst_recover got done_at=%0d ld=%h fault_at=%0d want 2 12345678 -1", r_done_at, r_ld, r_fault_at); end
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_store_word;
    test_store_sub;
    test_loads;
    test_faults;
    test_timeout;
    test_reset_mid_busy;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU. It takes the ALU Result as the effective address and runs one data-memory transaction per load or store instruction over a req/ack bus.
- It generates byte enables and replicated store data, and returns aligned, sign- or zero-extended load data for writeback.
- It holds the single-cycle core with a stall until the transaction completes.
- It flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY waiting for dmem_ack before the access is aborted. Range 1..65535.
- CNT_W, 16: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store.
- funct3  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw.
- addr  in  32  effective address (ALU Result).
- store_data  in  32  rs2 value.
- dmem_req  out  1  bus request, held until the ack cycle.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address: addr with bits [1:0] forced to 00.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  transaction complete; read data valid in the same cycle.
- dmem_rdata  in  32  read word.
- stall  out  1  core must hold PC and the instruction.
- load_data  out  32  extended load result; valid while done=1.
- done  out  1  single-cycle completion pulse; the core commits this cycle.
- fault  out  1  single-cycle pulse for misaligned, illegal, or timeout.
- fault_cause  out  2  00 none, 01 misaligned, 10 illegal funct3 or read&write both set, 11 timeout.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state goes to IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data, done, fault, fault_cause all go to 0; counter goes to 0.
  - Reset mid-transaction drops dmem_req immediately. No done or fault pulse is produced.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read or mem_write is set and the access is legal and aligned: latch addr, we, be, wdata, funct3 and addr[1:0]; go to BUSY. stall=1 combinationally this cycle.
  - If the access is illegal or misaligned: stay in IDLE, no bus request. fault=1 and fault_cause set in the next cycle (registered). stall=0 so the core traps.
  - dmem_ack is ignored in IDLE.
- BUSY:
  - dmem_req=1 and stall=1; the counter increments each cycle.
  - Bus outputs stay stable from entry until the ack cycle, inclusive.
  - On dmem_ack: capture the extended dmem_rdata into load_data (stores capture 0) and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: drop req, set fault=1 with cause 11, go to IDLE with stall=0.
  - If ack arrives in the timeout cycle, ack wins.
- RESP:
  - done=1, stall=0, load_data held; unconditionally return to IDLE.
  - The same instruction is still present this cycle and must not restart the unit.
  - Minimum latency is 3 cycles (IDLE, BUSY with same-cycle ack, RESP).
- Alignment rules:
  - lw and sw need addr[1:0]=00.
  - lh, lhu and sh need addr[0]=0.
  - Bytes are always aligned.
- Illegal cases:
  - Load funct3 of 011, 110 or 111.
  - Store funct3 of 011 or higher.
  - mem_read and mem_write both set.
- Stores:
  - sb: be = 0001 shifted left by addr[1:0]; wdata = the low byte replicated 4 times.
  - sh: be = 0011 shifted left by addr[1]*2; wdata = the low half replicated 2 times.
  - sw: be = 1111; wdata = store_data.
- Loads:
  - Shift rdata right by 8 * addr[1:0].
  - lb and lh sign-extend from bit 7 and bit 15 respectively.
  - lbu and lhu zero-extend.
  - lw passes the word through unchanged.
- done and fault are never high in the same cycle.

Decomposition:
- Shared package holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - fault_cause codes.
- One combinational sub-module, lsu_load_align (rdata, byte_off, funct3 -> load_data), reused for the extract/extend path.

Test Plan:
- sw addr=0x100, data=0xDEADBEEF, ack 2 cycles after req -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF; stall for 3 cycles; done on the 4th cycle.
- sb addr=0x103, data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; lh addr=0x102 with rdata=0x8001xxxx -> load_data=0xFFFF8001.
- lbu addr=0x101 with rdata=0x0000F000 -> load_data=0x000000F0; lb with the same inputs -> 0xFFFFFFF0.
- lw addr=0x102 -> no dmem_req, fault=1 with cause 01, stall=0; funct3=011 load -> fault with cause 10.
- TIMEOUT_CYCLES=4, ack never arrives -> req high for 4 cycles, then fault with cause 11 and return to IDLE.
- rst_n low in the 2nd BUSY cycle -> dmem_req=0 asynchronously; no done or fault; a new load after release completes normally.
